// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, RV64 funct3 codes,
// captured-request record and the funct3-to-access-size helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] data;
  } lsu_req_t;

  // Access size in bytes; funct3[2] only selects the extension kind.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational data path: sign/zero extension of loads and byte-merge of a
// narrow store into the 8-byte word read back from memory.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] rd_data,
  input  logic [63:0] st_data,
  output logic [63:0] ld_data,
  output logic [63:0] merged
);

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  logic [3:0]                        n_bytes;
  logic                              sx;
  logic [NUM_LANES-1:0][VEC_W-1:0]   rd_b, st_b, mg_b;

  assign n_bytes = size_bytes(funct3);
  assign sx      = ~funct3[2];
  assign rd_b    = rd_data;
  assign st_b    = st_data;
  assign merged  = mg_b;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mg_b[i] = (4'(i) < n_bytes) ? st_b[i] : rd_b[i];
  end

  always_comb begin
    ld_data = '0;
    case (funct3[1:0])
      2'b00:   ld_data = {{56{sx & rd_data[7]}},  rd_data[7:0]};
      2'b01:   ld_data = {{48{sx & rd_data[15]}}, rd_data[15:0]};
      2'b10:   ld_data = {{32{sx & rd_data[31]}}, rd_data[31:0]};
      default: ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit over an 8-byte little-endian memory port.
// Stores are read-modify-write so bytes beyond the access size are preserved.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES   = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] Addr,
  input  logic [63:0] Store_Data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [63:0] Load_Data,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [63:0] Read_Data
);

  lsu_state_e  state, state_n;
  lsu_req_t    req_q;
  logic [63:0] merged_q, lane_ld, lane_merged;
  logic        fault_q;
  logic [3:0]  n_in;
  logic        misalign, out_of_range, illegal, req_fault;

  assign n_in         = size_bytes(funct3);
  assign misalign     = CHECK_ALIGN && ((Addr[3:0] & (n_in - 4'd1)) != 4'd0);
  assign out_of_range = Addr > 64'(MEM_BYTES - 8);
  assign illegal      = (is_load == is_store) || (funct3 == F3_BAD) ||
                        (is_store && funct3[2]);
  assign req_fault    = misalign || out_of_range || illegal;

  lsu_byte_lane u_lane (
    .funct3  (req_q.funct3),
    .rd_data (Read_Data),
    .st_data (req_q.data),
    .ld_data (lane_ld),
    .merged  (lane_merged)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (req_valid) state_n = req_fault ? ST_DONE : ST_READ;
      ST_READ:  state_n = req_q.is_load ? ST_DONE : ST_WRITE;
      ST_WRITE: state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    MemRead    = (state == ST_READ);
    MemWrite   = (state == ST_WRITE);
    Mem_Addr   = '0;
    Write_Data = '0;
    if (state == ST_READ || state == ST_WRITE) Mem_Addr = req_q.addr;
    if (state == ST_WRITE) Write_Data = merged_q;
  end

  assign fault = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      merged_q  <= '0;
      Load_Data <= '0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && req_valid) begin
        req_q.is_load <= is_load;
        req_q.funct3  <= funct3;
        req_q.addr    <= Addr;
        req_q.data    <= Store_Data;
      end
      if (state == ST_READ) begin
        if (req_q.is_load) Load_Data <= lane_ld;
        else               merged_q  <= lane_merged;
      end
      // fault only changes on entry to DONE so it stays paired with Load_Data
      if (state_n == ST_DONE && state != ST_DONE)
        fault_q <= (state == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-byte memory initialised to byte i = i.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [63:0] Addr, Store_Data;
  logic        busy, done, fault, MemRead, MemWrite;
  logic [63:0] Load_Data, Mem_Addr, Write_Data, Read_Data;

  load_store_unit #(.MEM_BYTES(64), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .Addr(Addr), .Store_Data(Store_Data),
    .busy(busy), .done(done), .fault(fault), .Load_Data(Load_Data),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemRead(MemRead),
    .MemWrite(MemWrite), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:63];
  logic [7:0] ref_mem [0:63];
  logic       init_mem;
  int         n_rd = 0, n_wr = 0, n_both = 0;
  int         n_chk = 0, n_err = 0;

  always_comb begin
    Read_Data = '0;
    for (int k = 0; k < 8; k++) Read_Data[k*8 +: 8] = mem[6'(Mem_Addr[5:0] + 6'(k))];
  end

  always @(negedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (MemWrite) begin
      for (int k = 0; k < 8; k++) mem[6'(Mem_Addr[5:0] + 6'(k))] <= Write_Data[k*8 +: 8];
    end
    if (MemRead) n_rd++;
    if (MemWrite) n_wr++;
    if (MemRead && MemWrite) n_both++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    if (f3[1:0] == 2'd2) return 4;
    return 8;
  endfunction

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [63:0] addr, sdata;
    logic        efault;
    int          ecyc;
    logic [63:0] edata;
  } vec_t;

  // Issues one request starting from IDLE and returns once the unit is back in IDLE.
  task automatic do_req(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd, input logic ef,
                        input int ecyc, input logic [63:0] ed);
    int cyc, rd0, wr0;
    @(negedge clk);
    rd0 = n_rd; wr0 = n_wr;
    is_load = ld; is_store = st; funct3 = f3; Addr = a; Store_Data = sd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " cycles"}, 64'(cyc), 64'(ecyc));
    chk({nm, " fault"}, 64'(fault), 64'(ef));
    chk({nm, " data"}, Load_Data, ed);
    chk({nm, " reads"}, 64'(n_rd - rd0), (ef ? 64'd0 : 64'd1));
    chk({nm, " writes"}, 64'(n_wr - wr0), (!ef && st) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    chk({nm, " idle"}, 64'(busy), 64'd0);
  endtask

  vec_t vt [$];
  logic [4:0] bbits, dbits;
  int wr0, bad;

  initial begin
    reset = 1'b0; init_mem = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; Addr = '0; Store_Data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);

    //      ld    st    f3    addr    sdata                    flt  cyc expected Load_Data
    vt.push_back('{1'b1, 1'b0, 3'd0, 64'h10, 64'h0,                  1'b0, 2, 64'h10});
    vt.push_back('{1'b0, 1'b1, 3'd0, 64'h08, 64'hAAAA_AAAA_AAAA_AAF0, 1'b0, 3, 64'h10});
    vt.push_back('{1'b1, 1'b0, 3'd0, 64'h08, 64'h0,                  1'b0, 2, 64'hFFFF_FFFF_FFFF_FFF0});
    vt.push_back('{1'b1, 1'b0, 3'd4, 64'h08, 64'h0,                  1'b0, 2, 64'hF0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 64'h08, 64'h0,                  1'b0, 2, 64'h0F0E_0D0C_0B0A_09F0});
    vt.push_back('{1'b0, 1'b1, 3'd3, 64'h20, 64'h1122_3344_5566_7788, 1'b0, 3, 64'h0F0E_0D0C_0B0A_09F0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 64'h20, 64'h0,                  1'b0, 2, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b1, 1'b0, 3'd1, 64'h11, 64'h0,                  1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b0, 1'b1, 3'd2, 64'h22, 64'hFFFF_FFFF,          1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b1, 1'b0, 3'd3, 64'h39, 64'h0,                  1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b1, 1'b0, 3'd7, 64'h00, 64'h0,                  1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b0, 1'b1, 3'd4, 64'h00, 64'h55,                 1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b1, 1'b1, 3'd0, 64'h00, 64'h55,                 1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b0, 1'b0, 3'd0, 64'h00, 64'h55,                 1'b1, 1, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b0, 1'b1, 3'd1, 64'h30, 64'h1234_5678_9ABC_8001, 1'b0, 3, 64'h1122_3344_5566_7788});
    vt.push_back('{1'b1, 1'b0, 3'd1, 64'h30, 64'h0,                  1'b0, 2, 64'hFFFF_FFFF_FFFF_8001});
    vt.push_back('{1'b1, 1'b0, 3'd5, 64'h30, 64'h0,                  1'b0, 2, 64'h8001});
    vt.push_back('{1'b1, 1'b0, 3'd6, 64'h30, 64'h0,                  1'b0, 2, 64'h3332_8001});
    vt.push_back('{1'b0, 1'b1, 3'd2, 64'h34, 64'hFFFF_FFFF_8000_0000, 1'b0, 3, 64'h3332_8001});
    vt.push_back('{1'b1, 1'b0, 3'd2, 64'h34, 64'h0,                  1'b0, 2, 64'hFFFF_FFFF_8000_0000});
    vt.push_back('{1'b1, 1'b0, 3'd6, 64'h34, 64'h0,                  1'b0, 2, 64'h8000_0000});
    vt.push_back('{1'b1, 1'b0, 3'd3, 64'h38, 64'h0,                  1'b0, 2, 64'h3F3E_3D3C_3B3A_3938});
    vt.push_back('{1'b1, 1'b0, 3'd2, 64'h20, 64'h0,                  1'b0, 2, 64'h5566_7788});
    vt.push_back('{1'b1, 1'b0, 3'd0, 64'h21, 64'h0,                  1'b0, 2, 64'h77});
    vt.push_back('{1'b1, 1'b0, 3'd3, 64'h30, 64'h0,                  1'b0, 2, 64'h8000_0000_3332_8001});
    vt.push_back('{1'b1, 1'b0, 3'd0, 64'h3F, 64'h0,                  1'b1, 1, 64'h8000_0000_3332_8001});

    @(negedge clk); @(negedge clk);
    init_mem = 1'b0;
    #1;
    chk("reset outputs", {59'(0), busy, done, fault, MemRead, MemWrite}, 64'd0);
    chk("reset Load_Data", Load_Data, 64'd0);
    chk("reset Mem_Addr", Mem_Addr | Write_Data, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      do_req($sformatf("vec%0d", i), vt[i].ld, vt[i].st, vt[i].f3, vt[i].addr, vt[i].sdata,
             vt[i].efault, vt[i].ecyc, vt[i].edata);
      if (vt[i].st && !vt[i].efault)
        for (int k = 0; k < nbytes(vt[i].f3); k++)
          ref_mem[vt[i].addr[5:0] + 6'(k)] = vt[i].sdata[k*8 +: 8];
    end

    // reset in the READ cycle of a store aborts it before any memory write
    @(negedge clk);
    wr0 = n_wr;
    is_load = 1'b0; is_store = 1'b1; funct3 = 3'd2; Addr = 64'h0;
    Store_Data = 64'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort in READ", 64'(MemRead), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort outputs", {59'(0), busy, done, fault, MemRead, MemWrite}, 64'd0);
    chk("abort Load_Data", Load_Data, 64'd0);
    chk("abort Mem_Addr", Mem_Addr | Write_Data, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort writes", 64'(n_wr - wr0), 64'd0);
    do_req("ld after abort", 1'b1, 1'b0, 3'd3, 64'h0, 64'h0, 1'b0, 2, 64'h0706_0504_0302_0100);

    // req_valid held high over two back-to-back lw 0x04
    @(negedge clk);
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; Addr = 64'h04; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bbits[k] = busy; dbits[k] = done;
    end
    req_valid = 1'b0;
    chk("b2b busy pattern", 64'(bbits), 64'(5'b11011));
    chk("b2b done pattern", 64'(dbits), 64'(5'b10010));
    chk("b2b data", Load_Data, 64'h0706_0504);
    @(posedge clk); #1;
    chk("b2b idle", 64'(busy), 64'd0);

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("memory image", 64'(bad), 64'd0);
    chk("read/write overlap", 64'(n_both), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, meaning data-memory size in bytes.
REQ-002 SHALL have parameter CHECK_ALIGN, default 1, meaning natural-alignment faulting is enabled when 1.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  access request, sampled only when busy=0.
REQ-006 SHALL have port is_load / is_store  input  1 each  access type.
REQ-007 SHALL have port funct3  input  3  RV64 width/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 SHALL have port Addr  input  64  byte address.
REQ-009 SHALL have port Store_Data  input  64  store operand, low N bytes used.
REQ-010 SHALL have port busy  output  1  high from acceptance until return to IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port fault  output  1  valid with done: misaligned, out-of-range or illegal request.
REQ-013 SHALL have port Load_Data  output  64  extended load result, held until next done.
REQ-014 SHALL have ports Mem_Addr  output  64, Write_Data  output  64, MemRead  output  1, MemWrite  output  1, Read_Data  input  64 -- the 8-byte little-endian data-memory port; memory writes on negedge clk, reads combinationally.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE; busy=0 only in IDLE; done=1 only in DONE.
REQ-016 SHALL accept a request at a rising edge in IDLE with req_valid=1, capturing Addr, funct3, type, Store_Data; req_valid in other states is ignored.
REQ-017 SHALL fault when: is_load==is_store; funct3=111; store with funct3[2]=1; CHECK_ALIGN=1 and Addr mod N != 0 (N=1,2,4,8); Addr > MEM_BYTES-8.
REQ-018 Faulting request SHALL go IDLE->DONE (done one edge after acceptance) with MemRead/MemWrite never asserted and Load_Data unchanged.
REQ-019 Load SHALL go IDLE->READ->DONE: MemRead=1 and Mem_Addr=Addr in READ; Read_Data sampled at READ exit; done one edge later than a fault.
REQ-020 Load_Data SHALL be the low N bytes of Read_Data, sign-extended for funct3[2]=0, zero-extended for funct3[2]=1.
REQ-021 Store SHALL go IDLE->READ->WRITE->DONE (read-modify-write): merged word = Read_Data with low N bytes replaced by Store_Data low N bytes, registered at READ exit.
REQ-022 In WRITE, MemWrite=1, Mem_Addr=Addr, Write_Data=merged word, for exactly one cycle; bytes Addr+N..Addr+7 SHALL be rewritten with their read values.
REQ-023 DONE SHALL always return to IDLE on the next edge; no request is accepted in the DONE cycle.
REQ-024 MemRead and MemWrite SHALL never be high together; outside READ/WRITE both are 0.
REQ-025 fault SHALL be 0 on successful completion and held with Load_Data until the next done.

Reset
REQ-026 reset=0 SHALL immediately force IDLE and busy, done, fault, MemRead, MemWrite to 0, and Load_Data, Mem_Addr, Write_Data to 0.
REQ-027 Reset during READ or WRITE SHALL abort the access; if asserted before the WRITE-cycle negedge, memory SHALL be unmodified.

Structure
REQ-028 A shared package lsu_pkg SHALL hold the state encoding, funct3 constants and the funct3-to-size (N) function.
REQ-029 A single combinational sub-module lsu_byte_lane SHALL perform load extension and store byte-merge.

Verification (bench memory initialised byte i = i, MEM_BYTES=64)
REQ-030 lb Addr=0x10 -> done one edge after READ, fault=0, Load_Data=0x10, MemWrite never high.
REQ-031 sb 0xF0 at 0x08, then lb 0x08 -> 0xFFFF_FFFF_FFFF_FFF0, lbu 0x08 -> 0xF0; bytes 0x09..0x0F still 0x09..0x0F.
REQ-032 sd 0x1122334455667788 at 0x20 (three states, one MemWrite pulse), then ld 0x20 -> 0x1122334455667788.
REQ-033 lh 0x11, sw 0x22, ld 0x39, funct3=111 -> each fault=1, done one edge after acceptance, no MemRead/MemWrite, memory unchanged.
REQ-034 sw 0xDEADBEEF at 0x00 with reset asserted during READ -> all outputs 0 immediately, no MemWrite, ld 0x00 after reset -> 0x0706050403020100.
REQ-035 req_valid held high throughout two back-to-back lw 0x04 requests -> second accepted only in IDLE after done, busy low exactly one cycle between them.
